uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word fall-through byte FIFO.
// The line is oversampled at div clocks per bit; the FSM state is exported on dbg_state.
module uart_rx_fifo #(
  parameter int div   = 4,
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(depth):0]   count,
  output logic                     frame_err,
  output logic                     overrun,
  output logic [2:0]               dbg_state
);

  localparam int TW = $clog2(div) + 1;
  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;

  localparam logic [TW-1:0] DIV_T      = TW'(div);
  localparam logic [TW-1:0] HALF_T     = TW'(div / 2);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(depth);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_e;

  // Handshake: the head byte moves on any rising edge where rd_valid && rd_ready;
  // rd_data is stable while rd_valid is high and not popped; rd_ready when empty is ignored.

  logic          rx_meta_q, rx_s_q;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tick;
  logic          push;
  logic          stop_bad;

  logic [7:0]    mem [depth];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          frame_err_q, overrun_q;
  logic          pop;
  logic          wr_en;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
    end
  end

  // A sample is taken on the edge where the down-counter would pass from 1 to 0.
  assign tick = (timer_q == TIMER_ONE);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    push     = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          timer_d = HALF_T;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_s_q) begin
            timer_d  = DIV_T;
            bitcnt_d = '0;
            state_d  = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          timer_d = DIV_T;
          if (bitcnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      S_WAIT_IDLE: begin
        // Hold off until the line returns high so a break is not read as 0x00 bytes.
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pop   = (count_q != '0) && rd_ready;
  // A full FIFO still accepts a byte when the consumer frees a slot in the same cycle.
  assign wr_en = push && ((count_q < DEPTH_C) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (wr_en && !pop) begin
        count_q <= count_q + CNT_ONE;
      end else if (pop && !wr_en) begin
        count_q <= count_q - CNT_ONE;
      end
      frame_err_q <= stop_bad;
      overrun_q   <= push && !wr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= shift_q;
    end
  end

  assign rd_valid  = (count_q != '0);
  assign rd_data   = mem[rd_ptr_q];
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (div=4, depth=16): frames are driven on the pin
// at falling clock edges and outputs are sampled at falling edges.
module tb_uart_rx_fifo;

  localparam int DIV   = 4;
  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic [4:0] count;
  logic       frame_err;
  logic       overrun;
  logic [2:0] dbg_state;

  int n_checks;
  int n_pass;
  int fe_cnt;
  int ov_cnt;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.div(DIV), .depth(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: counts cycles each error output is high.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  end

  // Driver: one 8N1 frame, each bit held DIV cycles; returns at the negedge
  // just before the stop-sample posedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b exp 0", rd_valid); else n_pass++;
    n_checks++;
    if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_pulses got fe=%b ov=%b exp 0 0", frame_err, overrun);
    else n_pass++;
    n_checks++;
    if (dbg_state !== 3'd0) $display("FAIL reset_state got %0d exp 0", dbg_state); else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte;
    send_frame(8'h55, 1'b1);
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL single_valid_early got %b exp 0", rd_valid); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rd_valid !== 1'b1) $display("FAIL single_valid_latency got %b exp 1", rd_valid); else n_pass++;
    n_checks++;
    if (rd_data !== 8'h55) $display("FAIL single_data got %h exp 55", rd_data); else n_pass++;
    n_checks++;
    if (count !== 5'd1) $display("FAIL single_count got %0d exp 1", count); else n_pass++;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    n_checks++;
    if (count !== 5'd0 || rd_valid !== 1'b0)
      $display("FAIL single_pop got count=%0d valid=%b exp 0 0", count, rd_valid);
    else n_pass++;
    rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    rd_ready = 1'b0;
    n_checks++;
    if (count !== 5'd0) $display("FAIL empty_ready_count got %0d exp 0", count); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int fe0, ov0;
    logic [7:0] e;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h48, 1'b1);
    send_frame(8'h69, 1'b1);
    send_frame(8'h0A, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (count !== 5'd3) $display("FAIL burst_count got %0d exp 3", count); else n_pass++;
    n_checks++;
    if (fe_cnt != fe0 || ov_cnt != ov0)
      $display("FAIL burst_pulses got fe=%0d ov=%0d exp 0 0", fe_cnt - fe0, ov_cnt - ov0);
    else n_pass++;
    exp_q.push_back(8'h48); exp_q.push_back(8'h69); exp_q.push_back(8'h0A);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== e)
        $display("FAIL burst_pop got valid=%b data=%h exp 1 %h", rd_valid, rd_data, e);
      else n_pass++;
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
    n_checks++;
    if (count !== 5'd0) $display("FAIL burst_drained got %0d exp 0", count); else n_pass++;
  endtask

  task automatic test_frame_error;
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0);
    repeat (30) @(negedge clk);
    n_checks++;
    if (fe_cnt - fe0 != 1) $display("FAIL ferr_pulse got %0d exp 1", fe_cnt - fe0); else n_pass++;
    n_checks++;
    if (count !== 5'd0) $display("FAIL ferr_no_push got %0d exp 0", count); else n_pass++;
    n_checks++;
    if (dbg_state !== 3'd4) $display("FAIL ferr_wait_idle got %0d exp 4", dbg_state); else n_pass++;
    rx = 1'b1;
    repeat (6) @(negedge clk);
    send_frame(8'h01, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (count !== 5'd1 || rd_data !== 8'h01)
      $display("FAIL ferr_next got count=%0d data=%h exp 1 01", count, rd_data);
    else n_pass++;
    n_checks++;
    if (fe_cnt - fe0 != 1) $display("FAIL ferr_single got %0d exp 1", fe_cnt - fe0); else n_pass++;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dbg_state !== 3'd1) $display("FAIL glitch_start got %0d exp 1", dbg_state); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dbg_state !== 3'd0) $display("FAIL glitch_idle got %0d exp 0", dbg_state); else n_pass++;
    repeat (40) @(negedge clk);
    n_checks++;
    if (count !== 5'd0 || rd_valid !== 1'b0)
      $display("FAIL glitch_count got count=%0d valid=%b exp 0 0", count, rd_valid);
    else n_pass++;
  endtask

  task automatic test_overrun;
    int ov0;
    logic [7:0] e;
    ov0 = ov_cnt;
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (count !== 5'd16) $display("FAIL ovr_count got %0d exp 16", count); else n_pass++;
    n_checks++;
    if (ov_cnt - ov0 != 1) $display("FAIL ovr_pulse got %0d exp 1", ov_cnt - ov0); else n_pass++;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== e)
        $display("FAIL ovr_pop got valid=%b data=%h exp 1 %h", rd_valid, rd_data, e);
      else n_pass++;
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end

    // Same fill, but the consumer pops on the 17th byte's stop-sample edge.
    ov0 = ov_cnt;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
    send_frame(8'h10, 1'b1);
    n_checks++;
    if (rd_data !== 8'h00 || count !== 5'd16)
      $display("FAIL ovr2_head got data=%h count=%0d exp 00 16", rd_data, count);
    else n_pass++;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (count !== 5'd16) $display("FAIL ovr2_count got %0d exp 16", count); else n_pass++;
    n_checks++;
    if (ov_cnt != ov0) $display("FAIL ovr2_no_pulse got %0d exp 0", ov_cnt - ov0); else n_pass++;
    for (int i = 1; i < 17; i++) exp_q.push_back(8'(i));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== e)
        $display("FAIL ovr2_pop got valid=%b data=%h exp 1 %h", rd_valid, rd_data, e);
      else n_pass++;
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] pb;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (count !== 5'd2) $display("FAIL rmf_pre_count got %0d exp 2", count); else n_pass++;
    pb = 8'h5A;
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = pb[i];
      repeat (DIV) @(negedge clk);
    end
    rx = pb[3];
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    n_checks++;
    if (count !== 5'd0 || rd_valid !== 1'b0)
      $display("FAIL rmf_flush got count=%0d valid=%b exp 0 0", count, rd_valid);
    else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++;
    if (count !== 5'd0) $display("FAIL rmf_no_partial got %0d exp 0", count); else n_pass++;
    send_frame(8'hC3, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (count !== 5'd1 || rd_data !== 8'hC3)
      $display("FAIL rmf_next got count=%0d data=%h exp 1 c3", count, rd_data);
    else n_pass++;
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; fe_cnt = 0; ov_cnt = 0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
